// File: rtl/seq_detector_param_if.sv
// Signal bundle for seq_detector_param: serial input, control and match outputs.
// pat_mask_in exists only when SEQ_DET_MASK_EN is defined.
interface seq_detector_param_if #(
    parameter int PAT_W = 4,
    parameter int CNT_W = 8
);
    logic             en;
    logic             x;
    logic             overlap;
    logic             pat_load;
    logic [PAT_W-1:0] pat_in;
`ifdef SEQ_DET_MASK_EN
    logic [PAT_W-1:0] pat_mask_in;
`endif
    logic             cnt_clr;
    logic             z;
    logic [CNT_W-1:0] match_cnt;

    modport master (
        output en, x, overlap, pat_load, pat_in, cnt_clr,
`ifdef SEQ_DET_MASK_EN
        output pat_mask_in,
`endif
        input  z, match_cnt
    );

    modport slave (
        input  en, x, overlap, pat_load, pat_in, cnt_clr,
`ifdef SEQ_DET_MASK_EN
        input  pat_mask_in,
`endif
        output z, match_cnt
    );
endinterface

// File: rtl/seq_detector_param.sv
// Parametrised serial pattern detector with runtime-loadable pattern and saturating match counter.
// Define SEQ_DET_MASK_EN to add a per-bit don't-care mask captured alongside the pattern.
module seq_detector_param #(
    parameter int               PAT_W   = 4,
    parameter logic [PAT_W-1:0] PAT_RST = 4'b1011,
    parameter int               CNT_W   = 8
) (
    input logic                 clk,
    input logic                 reset,
    seq_detector_param_if.slave bus
);
    localparam int               FILL_W    = $clog2(PAT_W + 1);
    localparam logic [FILL_W-1:0] FILL_FULL = FILL_W'(PAT_W);
    localparam logic [CNT_W-1:0]  CNT_MAX   = '1;

    logic [PAT_W-1:0]  pat_reg;
    logic [PAT_W-1:0]  hist_reg;
    logic [FILL_W-1:0] fill_reg;
    logic              z_reg;
    logic [CNT_W-1:0]  cnt_reg;

    logic [PAT_W-1:0]  w_next;
    logic [FILL_W-1:0] fill_next;
    logic [PAT_W-1:0]  care;
    logic [PAT_W-1:0]  bit_ok;
    logic              match;

`ifdef SEQ_DET_MASK_EN
    logic [PAT_W-1:0]  pat_mask_reg;
    assign care = ~pat_mask_reg;
`else
    assign care = '1;
`endif

    assign w_next    = {hist_reg[PAT_W-2:0], bus.x};
    assign fill_next = (fill_reg == FILL_FULL) ? FILL_FULL : fill_reg + FILL_W'(1);

    // Per-bit compare; masked positions always agree.
    generate
        for (genvar gi = 0; gi < PAT_W; gi++) begin : g_cmp
            assign bit_ok[gi] = !care[gi] || (w_next[gi] == pat_reg[gi]);
        end
    endgenerate

    assign match = (fill_next == FILL_FULL) && (&bit_ok);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            pat_reg  <= PAT_RST;
            hist_reg <= '0;
            fill_reg <= '0;
            z_reg    <= 1'b0;
`ifdef SEQ_DET_MASK_EN
            pat_mask_reg <= '0;
`endif
        end else begin
            z_reg <= 1'b0;
            if (bus.pat_load) begin
                pat_reg  <= bus.pat_in;
                fill_reg <= '0;
`ifdef SEQ_DET_MASK_EN
                pat_mask_reg <= bus.pat_mask_in;
`endif
            end else if (bus.en) begin
                hist_reg <= w_next;
                z_reg    <= match;
                // Non-overlapping mode demands a full fresh window after each hit.
                fill_reg <= (match && !bus.overlap) ? '0 : fill_next;
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt_reg <= '0;
        end else if (bus.cnt_clr) begin
            cnt_reg <= '0;
        end else if (!bus.pat_load && bus.en && match && (cnt_reg != CNT_MAX)) begin
            cnt_reg <= cnt_reg + CNT_W'(1);
        end
    end

    assign bus.z         = z_reg;
    assign bus.match_cnt = cnt_reg;
endmodule

// File: tb/tb_seq_detector_param.sv
// Scoreboard bench for seq_detector_param: directed cases plus randomized traffic
// against a queue-of-bits reference model.
module tb_seq_detector_param;
    localparam int               PAT_W   = 4;
    localparam int               CNT_W   = 2;
    localparam logic [PAT_W-1:0] PAT_RST = 4'b1011;
    localparam int               CNT_MAX = (1 << CNT_W) - 1;
`ifdef SEQ_DET_MASK_EN
    localparam bit MASK_ON = 1'b1;
`else
    localparam bit MASK_ON = 1'b0;
`endif

    logic clk = 1'b0;
    logic reset = 1'b0;
    always #5 clk = ~clk;

    seq_detector_param_if #(.PAT_W(PAT_W), .CNT_W(CNT_W)) bus ();

    seq_detector_param #(.PAT_W(PAT_W), .PAT_RST(PAT_RST), .CNT_W(CNT_W)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    typedef struct {
        int z;
        int cnt;
    } exp_t;

    exp_t exp_q[$];
    int   checks = 0;
    int   errors = 0;
    int   txn    = 0;

    // Reference model: bits seen since the last window restart, oldest first.
    bit [PAT_W-1:0] m_pat;
    bit [PAT_W-1:0] m_mask;
    bit             m_bits[$];
    int             m_cnt;

    task automatic check(input string name, input int act, input int req);
        checks++;
        if (act != req) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, req, $time);
        end
    endtask

    function automatic void model_reset();
        m_pat  = PAT_RST;
        m_mask = '0;
        m_bits.delete();
        m_cnt  = 0;
    endfunction

    function automatic exp_t model_step(input logic en, input logic x, input logic ov,
                                        input logic pl, input logic [PAT_W-1:0] pin,
                                        input logic [PAT_W-1:0] pmask, input logic clr);
        exp_t e;
        bit   hit = 1'b0;
        if (pl) begin
            m_pat  = pin;
            m_mask = MASK_ON ? pmask : '0;
            m_bits.delete();
        end else if (en) begin
            m_bits.push_back(x);
            if (m_bits.size() > PAT_W) void'(m_bits.pop_front());
            if (m_bits.size() == PAT_W) begin
                hit = 1'b1;
                for (int i = 0; i < PAT_W; i++)
                    if (!m_mask[PAT_W-1-i] && (m_bits[i] != m_pat[PAT_W-1-i])) hit = 1'b0;
            end
            if (hit && !ov) m_bits.delete();
        end
        if (clr) m_cnt = 0;
        else if (hit && m_cnt < CNT_MAX) m_cnt++;
        e.z   = int'(hit);
        e.cnt = m_cnt;
        return e;
    endfunction

    task automatic step(input logic en, input logic x, input logic ov, input logic pl,
                        input logic [PAT_W-1:0] pin, input logic [PAT_W-1:0] pmask,
                        input logic clr);
        @(negedge clk);
        bus.en       = en;
        bus.x        = x;
        bus.overlap  = ov;
        bus.pat_load = pl;
        bus.pat_in   = pin;
        bus.cnt_clr  = clr;
`ifdef SEQ_DET_MASK_EN
        bus.pat_mask_in = pmask;
`endif
        exp_q.push_back(model_step(en, x, ov, pl, pin, pmask, clr));
        @(posedge clk);
    endtask

    task automatic feed(input logic [31:0] bits, input int n, input logic ov);
        for (int i = n - 1; i >= 0; i--) step(1'b1, bits[i], ov, 1'b0, '0, '0, 1'b0);
    endtask

    task automatic load(input logic [PAT_W-1:0] pin, input logic [PAT_W-1:0] pmask);
        step(1'b1, 1'b1, 1'b1, 1'b1, pin, pmask, 1'b0);
    endtask

    // Asserted between edges so the asynchronous clear is visible before the next edge.
    task automatic apply_reset();
        #2;
        reset        = 1'b1;
        bus.en       = 1'b0;
        bus.pat_load = 1'b0;
        bus.cnt_clr  = 1'b0;
        model_reset();
        #1;
        check("reset_z", int'(bus.z), 0);
        check("reset_cnt", int'(bus.match_cnt), 0);
        @(negedge clk);
        reset = 1'b0;
    endtask

    task automatic check_cnt(input string name, input int req);
        #2;
        check(name, int'(bus.match_cnt), req);
    endtask

    // Monitor: compares every scheduled cycle against the scoreboard.
    initial begin
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                txn++;
                $display("txn %0d: z=%0d cnt=%0d (exp z=%0d cnt=%0d)",
                         txn, bus.z, bus.match_cnt, e.z, e.cnt);
                check("z", int'(bus.z), e.z);
                check("match_cnt", int'(bus.match_cnt), e.cnt);
            end
        end
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not complete, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        bus.en       = 1'b0;
        bus.x        = 1'b0;
        bus.overlap  = 1'b1;
        bus.pat_load = 1'b0;
        bus.pat_in   = '0;
        bus.cnt_clr  = 1'b0;
`ifdef SEQ_DET_MASK_EN
        bus.pat_mask_in = '0;
`endif
        model_reset();
        apply_reset();

        // Overlapping stream with two hits
        feed(32'b001011011, 9, 1'b1);
        check_cnt("t1_cnt", 2);
        apply_reset();
        feed(32'b001011011, 9, 1'b0);
        check_cnt("t2_cnt", 1);

        // Self-overlapping pattern
        apply_reset();
        load(4'b1111, 4'b0000);
        feed(32'b111111, 6, 1'b1);
        check_cnt("t3_cnt", 3);
        apply_reset();
        load(4'b1111, 4'b0000);
        feed(32'b111111, 6, 1'b0);
        check_cnt("t4_cnt", 1);

        // en gaps with don't-care x
        apply_reset();
        feed(32'b10, 2, 1'b1);
        for (int i = 0; i < 3; i++) step(1'b0, 1'bx, 1'b1, 1'b0, '0, '0, 1'b0);
        feed(32'b11, 2, 1'b1);
        check_cnt("t5_cnt", 1);

        // Saturation, then clear colliding with a hit
        apply_reset();
        feed(32'b1011011011011011, 16, 1'b1);
        check_cnt("t6_sat", 3);
        feed(32'b01, 2, 1'b1);
        step(1'b1, 1'b1, 1'b1, 1'b0, '0, '0, 1'b1);
        check_cnt("t6_clr", 0);

        // Reset with z pulse in flight, and mid-pattern
        apply_reset();
        feed(32'b1011, 4, 1'b1);
        apply_reset();
        feed(32'b101, 3, 1'b1);
        apply_reset();
        feed(32'b1, 1, 1'b1);
        check_cnt("t7_cnt", 0);

        // Reset reverts a runtime pattern
        load(4'b0110, 4'b0000);
        apply_reset();
        feed(32'b1011, 4, 1'b0);
        check_cnt("t8_cnt", 1);

`ifdef SEQ_DET_MASK_EN
        apply_reset();
        load(4'b1011, 4'b0100);
        feed(32'b11111011, 8, 1'b0);
        check_cnt("t9_mask", 2);
`endif

        // Randomized traffic
        apply_reset();
        for (int i = 0; i < 1500; i++) begin
            logic             en  = ($urandom_range(0, 9) < 8);
            logic             xb  = $urandom_range(0, 1);
            logic             ov  = $urandom_range(0, 1);
            logic             pl  = ($urandom_range(0, 99) < 3);
            logic             clr = ($urandom_range(0, 99) < 3);
            logic [PAT_W-1:0] pin = PAT_W'($urandom);
            logic [PAT_W-1:0] pm  = ($urandom_range(0, 3) == 0) ? PAT_W'($urandom) : '0;
            if (!en && $urandom_range(0, 1) == 1) xb = 1'bx;
            step(en, xb, ov, pl, pin, pm, clr);
            if ($urandom_range(0, 299) == 0) apply_reset();
        end

        for (int i = 0; i < 20 && exp_q.size() > 0; i++) @(posedge clk);
        #2;
        if (exp_q.size() > 0) begin
            errors++;
            $display("FAIL drain: %0d entries left, expected 0", exp_q.size());
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
